// File: rtl/click_array_if.sv
// click_array_if: button/mode inputs and per-channel strobe/state outputs.
// master = user/board side, slave = click_array.
interface click_array_if #(
  parameter int CH = 4
);
  logic [CH-1:0]   button;
  logic [CH-1:0]   mode;
  logic [CH-1:0]   led;
  logic [CH-1:0]   press;
  // "release" is a reserved SystemVerilog keyword, hence the suffix.
  logic [CH-1:0]   release_stb;
  logic [CH-1:0]   long_press;
  logic [CH*8-1:0] click_cnt;

  modport master (
    output button,
    output mode,
    input  led,
    input  press,
    input  release_stb,
    input  long_press,
    input  click_cnt
  );

  modport slave (
    input  button,
    input  mode,
    output led,
    output press,
    output release_stb,
    output long_press,
    output click_cnt
  );
endinterface

// File: rtl/click_array.sv
// click_array: per-channel sync, debounce, edge/long-press strobes, LED toggle.
// Ports: clk, rst (sync, active-low), bus (click_array_if.slave).
// bus: button/mode in; led, press, release_stb, long_press, click_cnt out.
// Macro CLICK_ARRAY_COUNT_EN enables the 8-bit click counters,
// otherwise click_cnt is tied to 0.
module click_array #(
  parameter int CH          = 4,
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int HOLD_W      = 16
) (
  input logic          clk,
  input logic          rst,
  click_array_if.slave bus
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_MAX =
    DBW'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_M1 =
    HOLD_W'(HOLD_CYCLES - 1);

  logic [CH-1:0]     s1;
  logic [CH-1:0]     s2;
  logic [CH-1:0]     stable;
  logic [CH-1:0]     stable_d;
  logic [CH-1:0]     press_q;
  logic [CH-1:0]     rel_q;
  logic [CH-1:0]     long_q;
  logic [CH-1:0]     long_seen;
  logic [CH-1:0]     led_q;
  logic [DBW-1:0]    db_cnt   [CH];
  logic [HOLD_W-1:0] hold_cnt [CH];

  logic [CH-1:0] press_n;
  logic [CH-1:0] rel_n;
  logic [CH-1:0] long_n;
  logic [CH-1:0] tog_n;

  // Strobes and the LED toggle are decided from the same edge so
  // led changes in the very cycle its press/release strobe is high.
  // Mode-1 toggle uses long_seen before the release clears it.
  always_comb begin
    press_n = stable & ~stable_d;
    rel_n   = ~stable & stable_d;
    tog_n   = (press_n & ~bus.mode)
            | (rel_n & bus.mode & ~long_seen);
    long_n  = '0;
    for (int i = 0; i < CH; i++) begin
      long_n[i] = stable[i]
                & (hold_cnt[i] == HOLD_M1)
                & ~long_seen[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      stable_d  <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      long_q    <= '0;
      long_seen <= '0;
      led_q     <= '0;
      for (int i = 0; i < CH; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      s1        <= bus.button;
      s2        <= s1;
      stable_d  <= stable;
      press_q   <= press_n;
      rel_q     <= rel_n;
      long_q    <= long_n;
      led_q     <= led_q ^ tog_n;
      long_seen <= (long_seen | long_n) & ~rel_n;
      for (int i = 0; i < CH; i++) begin
        if (s2[i] != stable[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            stable[i] <= s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
        if (!stable[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.led         = led_q;
  assign bus.press       = press_q;
  assign bus.release_stb = rel_q;
  assign bus.long_press  = long_q;

`ifdef CLICK_ARRAY_COUNT_EN
  logic [7:0] cnt [CH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (tog_n[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    bus.click_cnt = '0;
    for (int i = 0; i < CH; i++) begin
      bus.click_cnt[8*i +: 8] = cnt[i];
    end
  end
`else
  assign bus.click_cnt = '0;
`endif

endmodule

// File: tb/tb_click_array.sv
// tb_click_array: directed tests for click_array
// (reset, glitch, bounce, long press, simultaneous channels, counters).
module tb_click_array;
  localparam int CH   = 4;
  localparam int DB   = 16;
  localparam int HOLD = 50;
`ifdef CLICK_ARRAY_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  click_array_if #(.CH(CH)) bus ();

  click_array #(
    .CH(CH),
    .DB_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .HOLD_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.button = 4'hF;
    bus.mode = 4'h0;
    repeat (3) tick();
    checks++;
    if ({bus.led, bus.press, bus.release_stb,
         bus.long_press} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h want 0000",
        {bus.led, bus.press, bus.release_stb,
         bus.long_press});
    end
    checks++;
    if (bus.click_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h want 0",
        bus.click_cnt);
    end
    rst = 1'b1;
    repeat (DB + 2) tick();
    checks++;
    if (bus.press !== 4'h0) begin
      errors++;
      $display("FAIL press_early: got %h want 0",
        bus.press);
    end
    tick();
    checks++;
    if (bus.press !== 4'hF) begin
      errors++;
      $display("FAIL press_lat: got %h want f",
        bus.press);
    end
    checks++;
    if (bus.led !== 4'hF) begin
      errors++;
      $display("FAIL press_led: got %h want f",
        bus.led);
    end
    tick();
    checks++;
    if (bus.press !== 4'h0) begin
      errors++;
      $display("FAIL press_width: got %h want 0",
        bus.press);
    end
    bus.button = 4'h0;
    repeat (DB + 2) tick();
    checks++;
    if (bus.release_stb !== 4'h0) begin
      errors++;
      $display("FAIL rel_early: got %h want 0",
        bus.release_stb);
    end
    tick();
    checks++;
    if (bus.release_stb !== 4'hF) begin
      errors++;
      $display("FAIL rel_lat: got %h want f",
        bus.release_stb);
    end
    checks++;
    if (bus.led !== 4'hF) begin
      errors++;
      $display("FAIL rel_led: got %h want f",
        bus.led);
    end
    repeat (5) tick();
  endtask

  task automatic test_glitch();
    logic [CH-1:0] seen;
    int            np;
    seen = '0;
    bus.button[0] = 1'b1;
    repeat (10) tick();
    bus.button[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      seen |= bus.press;
    end
    checks++;
    if (seen !== 4'h0 || bus.led !== 4'hF) begin
      errors++;
      $display("FAIL glitch: press %h led %h want 0 f",
        seen, bus.led);
    end
    checks++;
    if (dut.db_cnt[0] !== 4'd0) begin
      errors++;
      $display("FAIL glitch_db: got %0d want 0",
        dut.db_cnt[0]);
    end
    np = 0;
    bus.button[0] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.press[0]) np++;
    end
    checks++;
    if (np != 1 || bus.led !== 4'hE) begin
      errors++;
      $display("FAIL hold_press: n %0d led %h want 1 e",
        np, bus.led);
    end
    bus.button[0] = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_bounce();
    int np;
    np = 0;
    for (int a = 0; a < 5; a++) begin
      bus.button[1] = 1'b1;
      repeat (3) begin
        tick();
        if (bus.press[1]) np++;
      end
      bus.button[1] = 1'b0;
      repeat (3) begin
        tick();
        if (bus.press[1]) np++;
      end
    end
    bus.button[1] = 1'b1;
    repeat (25) begin
      tick();
      if (bus.press[1]) np++;
    end
    checks++;
    if (np != 1 || bus.led !== 4'hC) begin
      errors++;
      $display("FAIL bounce: n %0d led %h want 1 c",
        np, bus.led);
    end
    bus.button[1] = 1'b0;
    repeat (25) tick();
  endtask

  task automatic test_long_press();
    int pt, lt, lc, rc;
    pt = -1;
    lt = -1;
    lc = 0;
    rc = 0;
    bus.mode[2] = 1'b1;
    bus.button[2] = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      if (k == 61) bus.button[2] = 1'b0;
      tick();
      if (bus.press[2]) pt = k;
      if (bus.long_press[2]) begin
        lc++;
        lt = k;
      end
      if (bus.release_stb[2]) rc++;
    end
    checks++;
    if (pt != DB + 3) begin
      errors++;
      $display("FAIL lp_press: at %0d want %0d",
        pt, DB + 3);
    end
    checks++;
    if (lc != 1 || lt != DB + 3 + HOLD - 1) begin
      errors++;
      $display("FAIL lp_pulse: n %0d at %0d want 1 %0d",
        lc, lt, DB + 3 + HOLD - 1);
    end
    checks++;
    if (rc != 1 || bus.led !== 4'hC) begin
      errors++;
      $display("FAIL lp_rel: n %0d led %h want 1 c",
        rc, bus.led);
    end
    lc = 0;
    bus.button[2] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      if (k == 21) bus.button[2] = 1'b0;
      tick();
      if (bus.long_press[2]) lc++;
    end
    checks++;
    if (lc != 0 || bus.led !== 4'h8) begin
      errors++;
      $display("FAIL short: long %0d led %h want 0 8",
        lc, bus.led);
    end
  endtask

  task automatic test_simultaneous();
    bus.mode = 4'b1000;
    bus.button = 4'b1001;
    repeat (DB + 3) tick();
    checks++;
    if (bus.press !== 4'h9 || bus.led !== 4'h9) begin
      errors++;
      $display("FAIL sim_press: p %h led %h want 9 9",
        bus.press, bus.led);
    end
    repeat (6) tick();
    bus.button = 4'h0;
    repeat (DB + 3) tick();
    checks++;
    if (bus.release_stb !== 4'h9 ||
        bus.led !== 4'h1) begin
      errors++;
      $display("FAIL sim_rel: r %h led %h want 9 1",
        bus.release_stb, bus.led);
    end
    repeat (5) tick();
  endtask

  task automatic test_counter();
    logic [31:0] exp_cnt;
    exp_cnt = CNT_EN ? 32'h02020203 : 32'h0;
    checks++;
    if (bus.click_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cnt_hist: got %h want %h",
        bus.click_cnt, exp_cnt);
    end
    rst = 1'b0;
    bus.button = 4'h0;
    bus.mode = 4'h0;
    repeat (2) tick();
    rst = 1'b1;
    checks++;
    if (bus.click_cnt !== 32'h0 || bus.led !== 4'h0) begin
      errors++;
      $display("FAIL cnt_rst: cnt %h led %h want 0 0",
        bus.click_cnt, bus.led);
    end
    for (int n = 0; n < 256; n++) begin
      bus.button[1] = 1'b1;
      repeat (20) tick();
      bus.button[1] = 1'b0;
      repeat (20) tick();
    end
    checks++;
    if (bus.click_cnt !== 32'h0 || bus.led !== 4'h0) begin
      errors++;
      $display("FAIL cnt_256: cnt %h led %h want 0 0",
        bus.click_cnt, bus.led);
    end
    bus.button[1] = 1'b1;
    repeat (20) tick();
    bus.button[1] = 1'b0;
    repeat (20) tick();
    exp_cnt = CNT_EN ? 32'h00000100 : 32'h0;
    checks++;
    if (bus.click_cnt !== exp_cnt || bus.led !== 4'h2) begin
      errors++;
      $display("FAIL cnt_257: cnt %h led %h want %h 2",
        bus.click_cnt, bus.led, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_counter();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end
endmodule

// File: doc/click_array.md
Name: click_array

Overview:
- Multi-channel successor to the single-button click/toggle block.
- Per channel: 2-FF synchroniser, counter debounce, rising/falling edge detect, long-press detection, and LED toggle with a selectable mode.
- Sits between raw board push-buttons and user logic.
- Provides one-cycle press, release and long-press strobes plus a registered toggle state per channel.

Parameters:
- CH, 4, number of independent button channels (≥1).
- DB_CYCLES, 16, consecutive clock cycles a synchronised input must differ from the debounced state before the state flips (≥2).
- HOLD_CYCLES, 1000, cycles of debounced-high after which a long press is flagged (≥2, < 2^HOLD_W).
- HOLD_W, 16, width of the per-channel hold counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- button  input  CH  raw asynchronous button levels, 1 = pressed.
- mode  input  CH  per-channel toggle mode: 0 = toggle on press, 1 = toggle on short-click release.
- led  output  CH  registered toggle state per channel.
- press  output  CH  one-cycle strobe on debounced rising edge.
- release  output  CH  one-cycle strobe on debounced falling edge.
- long_press  output  CH  one-cycle strobe when a hold reaches HOLD_CYCLES.
- click_cnt  output  CH*8  per-channel 8-bit click counters; channel i at bits [8i+7:8i].

Behaviour:
- Reset (rst=0 sampled at clk edge): clears sync FFs, debounced state, debounce and hold counters, long-seen flag, and all outputs (led, press, release, long_press, click_cnt) to 0. Reset mid-debounce or mid-hold discards progress. A button held through reset is re-detected as a new press after the full latency.
- Synchroniser: two FFs per channel (s1, s2); s2 feeds the debouncer.
- Debounce, per channel:
  - If s2 ≠ stable, db_cnt increments.
  - If s2 == stable, db_cnt clears to 0.
  - When db_cnt == DB_CYCLES-1 and s2 ≠ stable still holds, stable ← s2 and db_cnt ← 0.
  - A glitch shorter than DB_CYCLES cycles never changes stable.
- Edge strobes are registered:
  - press = stable & ~stable_d; release = ~stable & stable_d.
  - Each is high exactly one cycle.
- Latency: with button held constant, press asserts DB_CYCLES+3 clock edges after the first edge that samples the new level (2 sync + DB_CYCLES debounce + 1 strobe register). Release has the same latency.
- Hold counter:
  - Clears when stable=0.
  - Increments while stable=1, saturating at HOLD_CYCLES.
  - long_press pulses once in the cycle after hold_cnt reaches HOLD_CYCLES-1, i.e. HOLD_CYCLES cycles after stable rose. The long_seen flag is set at the same time.
  - long_seen clears on the release strobe.
  - No further long_press until the next press.
- Toggle:
  - mode[i]=0: led[i] inverts in the cycle press[i] is high.
  - mode[i]=1: led[i] inverts in the cycle release[i] is high, only if long_seen[i]=0 at that release (short click); a long press never toggles.
  - mode is sampled at the strobe cycle; changing mode mid-hold is legal and takes effect at the next strobe.
- Channels are fully independent; simultaneous events on any subset are all honoured in the same cycle.
- click_cnt[i] increments by 1 on every cycle led[i] toggles, wrapping 255→0.

Optional Feature:
- CLICK_ARRAY_COUNT_EN
- Defined: click_cnt counters are implemented as described.
- Undefined: the counter logic is omitted and click_cnt is driven constant 0. The port remains present so the port list is identical in both builds.

Test Plan:
- Reset: drive rst=0 for 3 cycles with button=4'hF → all outputs 0. Release reset with button still 4'hF → press=4'hF for one cycle exactly DB_CYCLES+3 edges later, and led=4'hF (mode=0).
- Glitch rejection (DB_CYCLES=16): pulse button[0] high for 10 cycles, then low → press stays 0, led unchanged, db_cnt back to 0. Hold for 16+ cycles → single press strobe.
- Bounce: 5 alternations of 3 cycles each, then stable high for 20 cycles → exactly one press and one led toggle on channel 1.
- Long press, mode=1 (HOLD_CYCLES=50): hold button[2] for 60 cycles, then release → long_press pulses once 50 cycles after press; release strobe occurs; led[2] unchanged. A 20-cycle hold then release → led[2] toggles on release.
- Simultaneous channels: press ch0 (mode 0) and ch3 (mode 1) on the same cycle → both press strobes in the same cycle; led[0] toggles at press, led[3] toggles at release.
- Counter, with CLICK_ARRAY_COUNT_EN defined: 257 short clicks on ch1 → click_cnt[15:8]=1 (wrap). Without the macro → click_cnt stays 0.
